// File: rtl/arm_pkg.sv
// Shared ARM execute-stage encodings: ALU commands, shifter types and forwarding selects.
package arm_pkg;

    localparam logic [3:0] EXE_CMD_MOV = 4'b0001;
    localparam logic [3:0] EXE_CMD_MVN = 4'b1001;
    localparam logic [3:0] EXE_CMD_ADD = 4'b0010;
    localparam logic [3:0] EXE_CMD_ADC = 4'b0011;
    localparam logic [3:0] EXE_CMD_SUB = 4'b0100;
    localparam logic [3:0] EXE_CMD_SBC = 4'b0101;
    localparam logic [3:0] EXE_CMD_AND = 4'b0110;
    localparam logic [3:0] EXE_CMD_ORR = 4'b0111;
    localparam logic [3:0] EXE_CMD_EOR = 4'b1000;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled for port wiring.
interface exe_stage_if #(parameter int DW = 32);
    logic          freeze;
    logic          wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]    exe_cmd;
    logic [DW-1:0] pc_in, val_rn, val_rm;
    logic [11:0]   shift_operand;
    logic [23:0]   signed_imm_24;
    logic [3:0]    dest_in;
    logic [1:0]    sel_src1, sel_src2;
    logic [DW-1:0] mem_fwd_val, wb_fwd_val;
    logic          branch_taken;
    logic [DW-1:0] branch_addr;
    logic [3:0]    sr;
    logic          wb_en, mem_r_en, mem_w_en;
    logic [DW-1:0] alu_res, st_val;
    logic [3:0]    dest;

    modport slave (
        input  freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
        input  exe_cmd, pc_in, val_rn, val_rm, shift_operand, signed_imm_24, dest_in,
        input  sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
        output branch_taken, branch_addr, sr, wb_en, mem_r_en, mem_w_en, alu_res, st_val, dest
    );

    modport master (
        output freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in,
        output exe_cmd, pc_in, val_rn, val_rm, shift_operand, signed_imm_24, dest_in,
        output sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
        input  branch_taken, branch_addr, sr, wb_en, mem_r_en, mem_w_en, alu_res, st_val, dest
    );
endinterface

// File: rtl/val2_generator.sv
// Second ALU operand: memory offset, rotated 8-bit immediate, or shifted register.
module val2_generator
    import arm_pkg::*;
(
    input  logic [11:0] shift_operand,
    input  logic        imm,
    input  logic        mem_en,
    input  logic [31:0] rm,
    output logic [31:0] val2
);
    logic [4:0] w_amt;
    assign w_amt = shift_operand[11:7];

    always_comb begin
        val2 = rm;
        if (mem_en) begin
            val2 = {20'd0, shift_operand};
        end else if (imm) begin
            val2 = ror32({24'd0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
        end else begin
            // amount 0 leaves rm unchanged for every shift type
            case (shift_operand[6:5])
                SHIFT_LSL: val2 = rm << w_amt;
                SHIFT_LSR: val2 = rm >> w_amt;
                SHIFT_ASR: val2 = $signed(rm) >>> w_amt;
                SHIFT_ROR: val2 = ror32(rm, w_amt);
                default:   val2 = rm;
            endcase
        end
    end
endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding, ALU with NZCV register, branch target, EX/MEM register.
module exe_stage
    import arm_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic         clk,
    input  logic         rst,
    exe_stage_if.slave   bus
);
    logic [DW-1:0] w_op1, w_rm, w_val2, w_b, w_res;
    logic [DW:0]   w_sum;
    logic          w_arith, w_valid, w_c, w_v;
    logic [3:0]    r_sr;
    logic          r_wb_en, r_mem_r_en, r_mem_w_en;
    logic [DW-1:0] r_alu_res, r_st_val;
    logic [3:0]    r_dest;

    always_comb begin
        case (bus.sel_src1)
            FWD_ID:  w_op1 = bus.val_rn;
            FWD_MEM: w_op1 = bus.mem_fwd_val;
            FWD_WB:  w_op1 = bus.wb_fwd_val;
            default: w_op1 = bus.val_rn;
        endcase
        case (bus.sel_src2)
            FWD_ID:  w_rm = bus.val_rm;
            FWD_MEM: w_rm = bus.mem_fwd_val;
            FWD_WB:  w_rm = bus.wb_fwd_val;
            default: w_rm = bus.val_rm;
        endcase
    end

    val2_generator u_val2 (
        .shift_operand (bus.shift_operand),
        .imm           (bus.imm_in),
        .mem_en        (bus.mem_r_en_in | bus.mem_w_en_in),
        .rm            (w_rm),
        .val2          (w_val2)
    );

    // Subtracts are op1 + ~val2 + carry-in, so C is ARM's no-borrow flag.
    always_comb begin
        w_res   = '0;
        w_sum   = '0;
        w_b     = w_val2;
        w_arith = 1'b0;
        w_valid = 1'b1;
        w_c     = r_sr[1];
        w_v     = r_sr[0];
        case (bus.exe_cmd)
            EXE_CMD_MOV: w_res = w_val2;
            EXE_CMD_MVN: w_res = ~w_val2;
            EXE_CMD_ADD: begin
                w_arith = 1'b1;
                w_sum   = {1'b0, w_op1} + {1'b0, w_val2};
            end
            EXE_CMD_ADC: begin
                w_arith = 1'b1;
                w_sum   = {1'b0, w_op1} + {1'b0, w_val2} + {{DW{1'b0}}, r_sr[1]};
            end
            EXE_CMD_SUB: begin
                w_arith = 1'b1;
                w_b     = ~w_val2;
                w_sum   = {1'b0, w_op1} + {1'b0, ~w_val2} + {{DW{1'b0}}, 1'b1};
            end
            EXE_CMD_SBC: begin
                w_arith = 1'b1;
                w_b     = ~w_val2;
                w_sum   = {1'b0, w_op1} + {1'b0, ~w_val2} + {{DW{1'b0}}, r_sr[1]};
            end
            EXE_CMD_AND: w_res = w_op1 & w_val2;
            EXE_CMD_ORR: w_res = w_op1 | w_val2;
            EXE_CMD_EOR: w_res = w_op1 ^ w_val2;
            default:     w_valid = 1'b0;
        endcase
        if (w_arith) begin
            w_res = w_sum[DW-1:0];
            w_c   = w_sum[DW];
            w_v   = (w_op1[DW-1] == w_b[DW-1]) && (w_res[DW-1] != w_op1[DW-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr       <= '0;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_alu_res  <= '0;
            r_st_val   <= '0;
            r_dest     <= '0;
        end else if (!bus.freeze) begin
            r_wb_en    <= bus.wb_en_in;
            r_mem_r_en <= bus.mem_r_en_in;
            r_mem_w_en <= bus.mem_w_en_in;
            r_alu_res  <= w_res;
            r_st_val   <= w_rm;
            r_dest     <= bus.dest_in;
            if (bus.s_in && w_valid) begin
                r_sr <= {w_res[DW-1], (w_res == '0), w_c, w_v};
            end
        end
    end

    assign bus.branch_taken = bus.b_in;
    assign bus.branch_addr  = bus.pc_in + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};
    assign bus.sr           = r_sr;
    assign bus.wb_en        = r_wb_en;
    assign bus.mem_r_en     = r_mem_r_en;
    assign bus.mem_w_en     = r_mem_w_en;
    assign bus.alu_res      = r_alu_res;
    assign bus.st_val       = r_st_val;
    assign bus.dest         = r_dest;
endmodule
